// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg
//   Shared constants for the iterative multiply/divide unit: operand width,
//   MDop encodings seen by the control FSM, and the unit's state encoding.
package muldiv_unit_pkg;

  localparam int MD_DATA_WIDTH = 32;

  // Operation select; bit 1 distinguishes divide from multiply.
  typedef enum logic [1:0] {
    MD_MULLO = 2'b00,
    MD_MULHI = 2'b01,
    MD_DIVU  = 2'b10,
    MD_REMU  = 2'b11
  } mdop_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } md_state_e;

  // True for the divide family (DIVU/REMU).
  function automatic logic md_is_div(input mdop_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_unit_step.sv
// muldiv_step
//   Combinational single iteration of the multiply/divide datapath.
//   Ports:
//     i_div        : 1 = restoring-divide step, 0 = shift-add multiply step
//     i_hi / i_lo  : working register halves (product hi/lo or rem/quo)
//     i_a          : multiplicand (multiply only)
//     i_b          : divisor (divide only)
//     i_bit        : multiplier bit (multiply) or next dividend bit (divide)
//     o_hi / o_lo  : working register after this iteration
module muldiv_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_div,
  input  logic [DATA_WIDTH-1:0] i_hi,
  input  logic [DATA_WIDTH-1:0] i_lo,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic                  i_bit,
  output logic [DATA_WIDTH-1:0] o_hi,
  output logic [DATA_WIDTH-1:0] o_lo
);

  logic [DATA_WIDTH:0] w_sum;
  logic [DATA_WIDTH:0] w_shift;
  logic [DATA_WIDTH:0] w_diff;

  // One shift-add or shift-subtract iteration.
  always_comb begin
    w_sum   = {1'b0, i_hi} + (i_bit ? {1'b0, i_a} : {(DATA_WIDTH+1){1'b0}});
    w_shift = {i_hi, i_bit};
    // The partial remainder is always below the divisor, so the shifted
    // value is below 2*divisor and the top bit of the 33-bit difference is
    // exactly the borrow.
    w_diff  = w_shift - {1'b0, i_b};
    o_hi    = i_hi;
    o_lo    = i_lo;
    if (i_div) begin
      o_lo = {i_lo[DATA_WIDTH-2:0], ~w_diff[DATA_WIDTH]};
      if (w_diff[DATA_WIDTH]) begin
        o_hi = w_shift[DATA_WIDTH-1:0];
      end else begin
        o_hi = w_diff[DATA_WIDTH-1:0];
      end
    end else begin
      // Shift {carry, hi, lo} right by one.
      o_hi = w_sum[DATA_WIDTH:1];
      o_lo = {w_sum[0], i_lo[DATA_WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative unsigned 32-bit multiply/divide, one iteration per cycle,
//   fixed 33-edge latency from acceptance to out_valid.
//   Ports:
//     clk, rst            : clock, synchronous active-low reset
//     in_valid / in_ready : operand handshake (in_ready high only in IDLE)
//     A, B, MDop          : operands and operation (captured on acceptance)
//     out_valid/out_ready : result handshake (out_valid high only in DONE)
//     Result, Zero        : selected result and Result==0 flag
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int DATA_WIDTH = MD_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [1:0]            MDop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Zero
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  md_state_e             r_state;
  md_state_e             w_state_nxt;
  logic                  w_accept;
  logic                  w_last;
  mdop_e                 r_op;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_hi;
  logic [DATA_WIDTH-1:0] r_lo;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  w_bit;
  logic [DATA_WIDTH-1:0] w_hi_nxt;
  logic [DATA_WIDTH-1:0] w_lo_nxt;
  logic [DATA_WIDTH-1:0] w_res_sel;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and handshake strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_BUSY;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (r_cnt == LAST) begin
          w_last      = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Multiply consumes B LSB-first; divide feeds A into the remainder MSB-first.
  always_comb begin
    if (md_is_div(r_op)) begin
      w_bit = r_a[LAST - r_cnt];
    end else begin
      w_bit = r_b[r_cnt];
    end
  end

  muldiv_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .i_div (md_is_div(r_op)),
    .i_hi  (r_hi),
    .i_lo  (r_lo),
    .i_a   (r_a),
    .i_b   (r_b),
    .i_bit (w_bit),
    .o_hi  (w_hi_nxt),
    .o_lo  (w_lo_nxt)
  );

  // Result selection from the final iteration's output.
  always_comb begin
    case (r_op)
      MD_MULLO: w_res_sel = w_lo_nxt;
      MD_MULHI: w_res_sel = w_hi_nxt;
      MD_DIVU:  w_res_sel = w_lo_nxt;
      MD_REMU:  w_res_sel = w_hi_nxt;
      default:  w_res_sel = {DATA_WIDTH{1'b0}};
    endcase
  end

  // Operand capture, iteration registers and result register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_op     <= MD_MULLO;
      r_a      <= {DATA_WIDTH{1'b0}};
      r_b      <= {DATA_WIDTH{1'b0}};
      r_hi     <= {DATA_WIDTH{1'b0}};
      r_lo     <= {DATA_WIDTH{1'b0}};
      r_cnt    <= {CW{1'b0}};
      r_result <= {DATA_WIDTH{1'b0}};
    end else if (w_accept) begin
      r_op  <= mdop_e'(MDop);
      r_a   <= A;
      r_b   <= B;
      r_hi  <= {DATA_WIDTH{1'b0}};
      r_lo  <= {DATA_WIDTH{1'b0}};
      r_cnt <= {CW{1'b0}};
    end else if (r_state == ST_BUSY) begin
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
      if (w_last) begin
        r_result <= w_res_sel;
      end
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign Result    = r_result;
  assign Zero      = (r_result == {DATA_WIDTH{1'b0}});

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [1:0]  MDop;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Result;
  logic        Zero;

  int n_tests;
  int n_fail;

  muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .MDop      (MDop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .Zero      (Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: plain 64-bit arithmetic, divide-by-zero gives
  // all-ones quotient and the dividend as remainder.
  function automatic logic [31:0] ref_md(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Issue one op (called at posedge+1 with the unit idle); returns the result
  // when out_valid rises and the edge count from acceptance, acceptance edge
  // included. Leaves the result pending (out_ready untouched).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        output logic [31:0] res, output logic z, output int lat);
    int k;
    k = 0;
    while (in_ready !== 1'b1 && k < 100) begin
      @(posedge clk); #1; k++;
    end
    A = a; B = b; MDop = op; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = $urandom; B = $urandom; MDop = 2'($urandom_range(3, 0));
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    res = Result;
    z   = Zero;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || Result !== 32'd0 || Zero !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: in_ready=%b out_valid=%b Result=%h Zero=%b, want 1 0 00000000 1",
               in_ready, out_valid, Result, Zero);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] e;
  } vec_t;

  task automatic test_directed();
    vec_t v[9];
    logic [31:0] res;
    logic z;
    int lat;
    v[0] = '{32'd3, 32'd5, 2'b00, 32'h0000_000F};
    v[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 32'hFFFF_FFFE};
    v[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'h0000_0001};
    v[3] = '{32'd100, 32'd7, 2'b10, 32'd14};
    v[4] = '{32'd100, 32'd7, 2'b11, 32'd2};
    v[5] = '{32'd5, 32'd9, 2'b10, 32'd0};
    v[6] = '{32'd5, 32'd9, 2'b11, 32'd5};
    v[7] = '{32'h1234_5678, 32'd0, 2'b10, 32'hFFFF_FFFF};
    v[8] = '{32'h1234_5678, 32'd0, 2'b11, 32'h1234_5678};
    for (int i = 0; i < 9; i++) begin
      run_op(v[i].a, v[i].b, v[i].op, res, z, lat);
      n_tests++;
      if (res !== v[i].e || z !== (v[i].e == 32'd0) || lat !== 33) begin
        n_fail++;
        $display("FAIL directed[%0d]: Result=%h Zero=%b latency=%0d, want %h %b 33",
                 i, res, z, lat, v[i].e, (v[i].e == 32'd0));
      end
      take_result();
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL directed_release[%0d]: in_ready=%b out_valid=%b, want 1 0",
                 i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, res, e;
    logic [1:0] op;
    logic z;
    int lat;
    for (int i = 0; i < 24; i++) begin
      a  = $urandom;
      op = 2'($urandom_range(3, 0));
      case (i % 4)
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(15, 1));
        default: b = $urandom;
      endcase
      e = ref_md(op, a, b);
      run_op(a, b, op, res, z, lat);
      n_tests++;
      if (res !== e || z !== (e == 32'd0) || lat !== 33) begin
        n_fail++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: Result=%h Zero=%b latency=%0d, want %h %b 33",
                 i, op, a, b, res, z, lat, e, (e == 32'd0));
      end
      take_result();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, res, e;
    logic z;
    int lat;
    int bad;
    a = $urandom; b = $urandom;
    e = ref_md(2'b01, a, b);
    run_op(a, b, 2'b01, res, z, lat);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; A = $urandom; B = $urandom; MDop = 2'($urandom_range(3, 0));
      @(posedge clk); #1;
      if (Result !== e || Zero !== (e == 32'd0) || out_valid !== 1'b1 || in_ready !== 1'b0)
        bad++;
    end
    in_valid = 1'b0;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL backpressure_hold: %0d bad cycles (last Result=%h out_valid=%b in_ready=%b), want Result=%h out_valid=1 in_ready=0",
               bad, Result, out_valid, in_ready, e);
    end
    take_result();
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b, want 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    logic z;
    int lat;
    A = 32'hDEAD_BEEF; B = 32'd3; MDop = 2'b10; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    run_op(32'd6, 32'd7, 2'b00, res, z, lat);
    n_tests++;
    if (res !== 32'd42 || z !== 1'b0 || lat !== 33) begin
      n_fail++;
      $display("FAIL reset_mid_mullo: Result=%0d Zero=%b latency=%0d, want 42 0 33", res, z, lat);
    end
    take_result();
  endtask

  task automatic test_back_to_back();
    logic [31:0] expq[$];
    int acc_edge[$];
    logic acc, ho, both;
    logic [31:0] r, e;
    int edge_n, issued, got;
    both = 1'b0;
    edge_n = 0; issued = 0; got = 0;
    out_ready = 1'b1;
    A = $urandom; B = $urandom; MDop = 2'($urandom_range(3, 0)); in_valid = 1'b1;
    while (got < 3 && edge_n < 400) begin
      acc = in_ready & in_valid;
      ho  = out_valid & out_ready;
      r   = Result;
      if (in_ready && out_valid) both = 1'b1;
      @(posedge clk); #1;
      edge_n++;
      if (acc) begin
        acc_edge.push_back(edge_n);
        expq.push_back(ref_md(MDop, A, B));
        issued++;
        if (issued < 3) begin
          A = $urandom; B = $urandom; MDop = 2'($urandom_range(3, 0));
        end else begin
          in_valid = 1'b0;
        end
      end
      if (ho) begin
        e = (expq.size() > 0) ? expq.pop_front() : 32'hx;
        n_tests++;
        if (r !== e) begin
          n_fail++;
          $display("FAIL back_to_back_result[%0d]: Result=%h, want %h", got, r, e);
        end
        got++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_tests++;
    if (got != 3 || acc_edge.size() != 3) begin
      n_fail++;
      $display("FAIL back_to_back_count: results=%0d accepts=%0d, want 3 3", got, acc_edge.size());
    end else begin
      n_tests++;
      if (acc_edge[1] - acc_edge[0] != 34 || acc_edge[2] - acc_edge[1] != 34) begin
        n_fail++;
        $display("FAIL back_to_back_interval: %0d %0d, want 34 34",
                 acc_edge[1] - acc_edge[0], acc_edge[2] - acc_edge[1]);
      end
    end
    n_tests++;
    if (both) begin
      n_fail++;
      $display("FAIL ready_valid_exclusive: in_ready and out_valid seen high together, want never");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    A = 32'd0;
    B = 32'd0;
    MDop = 2'b00;
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
